// File: rtl/bsort_stream_if.sv
// Valid/ready stream pair for bsort_stream: load side (in_*) and drain side (out_*).
// slave is the sorter's view, master is the producer/consumer view.
interface bsort_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             descend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, descend, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, descend, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bsort_stream.sv
// Streaming bubble sorter: load DEPTH words, sort in place with one compare per cycle
// and early termination on a swap-free pass, then drain the sorted array.
module bsort_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 15,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  bsort_stream_if.slave    strm,
  output logic             busy,
  output logic             sorting_done,
  output logic [IDX_W-1:0] pass_count
);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          arr_q [DEPTH];
  logic [WIDTH-1:0]          arr_d [DEPTH];
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]          rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]          j_q, j_d;
  logic [IDX_W-1:0]          pass_q, pass_d;
  logic [IDX_W-1:0]          pass_count_q, pass_count_d;
  logic                      swapped_q, swapped_d;
  logic                      mode_q, mode_d;
  logic                      in_ready_q, in_ready_d;
  logic                      sorting_done_q, sorting_done_d;

  logic [IDX_W-1:0] j_nx;
  logic [IDX_W-1:0] limit_m1;
  logic [WIDTH-1:0] elem_a, elem_b;
  logic             swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= LOAD;
      arr_q          <= '{default: '0};
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      j_q            <= '0;
      pass_q         <= '0;
      pass_count_q   <= '0;
      swapped_q      <= 1'b0;
      mode_q         <= 1'b0;
      in_ready_q     <= 1'b0;
      sorting_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      arr_q          <= arr_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      j_q            <= j_d;
      pass_q         <= pass_d;
      pass_count_q   <= pass_count_d;
      swapped_q      <= swapped_d;
      mode_q         <= mode_d;
      in_ready_q     <= in_ready_d;
      sorting_done_q <= sorting_done_d;
    end
  end

  always_comb begin
    j_nx     = j_q + 1'b1;
    limit_m1 = LAST_PASS - pass_q;
    elem_a   = arr_q[j_q];
    elem_b   = arr_q[j_nx];
    swap     = mode_q ? (elem_a < elem_b) : (elem_a > elem_b);
  end

  always_comb begin
    state_d        = state_q;
    arr_d          = arr_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    j_d            = j_q;
    pass_d         = pass_q;
    pass_count_d   = pass_count_q;
    swapped_d      = swapped_q;
    mode_d         = mode_q;
    in_ready_d     = in_ready_q;
    sorting_done_d = 1'b0;

    unique case (state_q)
      LOAD: begin
        // in_ready comes up on the first edge out of reset
        in_ready_d = 1'b1;
        if (strm.in_valid && in_ready_q) begin
          arr_d[wr_idx_q] = strm.in_data;
          wr_idx_d        = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            mode_d     = strm.descend;
            j_d        = '0;
            swapped_d  = 1'b0;
            pass_d     = '0;
            in_ready_d = 1'b0;
            state_d    = SORT;
          end
        end
      end
      SORT: begin
        if (swap) begin
          arr_d[j_q]  = elem_b;
          arr_d[j_nx] = elem_a;
          swapped_d   = 1'b1;
        end
        if (j_q == limit_m1) begin
          pass_d = pass_q + 1'b1;
          // current compare counts toward this pass's swap flag
          if (!(swapped_q || swap) || pass_q == LAST_PASS) begin
            pass_count_d   = pass_q + 1'b1;
            sorting_done_d = 1'b1;
            state_d        = DRAIN;
          end else begin
            j_d       = '0;
            swapped_d = 1'b0;
          end
        end else begin
          j_d = j_nx;
        end
      end
      DRAIN: begin
        if (strm.out_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d   = '0;
            wr_idx_d   = '0;
            in_ready_d = 1'b1;
            state_d    = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign strm.in_ready  = in_ready_q;
  assign strm.out_valid = (state_q == DRAIN);
  assign strm.out_data  = (state_q == DRAIN) ? arr_q[rd_idx_q] : '0;
  assign busy           = (state_q == SORT);
  assign sorting_done   = sorting_done_q;
  assign pass_count     = pass_count_q;
endmodule

// File: doc/bsort_stream.md
# bsort_stream

Parametrised streaming bubble sorter for the FPGA sorting demos. It accepts DEPTH unsigned words over a valid/ready input stream, sorts them in place in ascending or descending order, and returns them over a valid/ready output stream. Early termination stops the sort after the first pass with no swaps. `sorting_done` and `pass_count` give benches a direct execution-time and throughput measurement.

## Interface

**Parameters**
- `WIDTH`, default 8: element width in bits. Elements are unsigned.
- `DEPTH`, default 15: number of elements per sort. Must be at least 2.
- `IDX_W`, default 4: index/counter width. Must satisfy 2^IDX_W ≥ DEPTH.

**Ports** (one clock; reset is asynchronous and active-high)
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous active-high reset.
- `in_valid`, in, 1: input element valid.
- `in_ready`, out, 1: block accepts input. Registered.
- `in_data`, in, WIDTH: input element.
- `descend`, in, 1: sort order, 0 = ascending, 1 = descending. Sampled on the last input handshake.
- `out_valid`, out, 1: sorted element valid.
- `out_ready`, in, 1: downstream accepts output.
- `out_data`, out, WIDTH: sorted element.
- `busy`, out, 1: high while in SORT.
- `sorting_done`, out, 1: one-cycle pulse when the sort completes.
- `pass_count`, out, IDX_W: passes executed by the last sort. Held until the next sort starts.

## Operation

**State machine:** LOAD → SORT → DRAIN → LOAD.

**LOAD**
- `in_ready`=1.
- Each cycle with `in_valid && in_ready`: `arr[wr_idx] <= in_data`, then `wr_idx++`.
- On the handshake at `wr_idx == DEPTH-1`:
  - latch `descend` into `mode`;
  - clear `j`, `swapped` and `pass`;
  - `in_ready <= 0`;
  - go to SORT.

**SORT**
- One compare per cycle on `arr[j]` and `arr[j+1]`.
- Swap condition:
  - ascending: `arr[j] > arr[j+1]`;
  - descending: `arr[j] < arr[j+1]`.
- Equal elements never swap, so the sort is stable.
- The pass limit shrinks each pass: `limit = DEPTH-1-pass`. `j` runs 0 to `limit-1`.
- At `j == limit-1` (end of pass):
  - `pass++`;
  - if no swap occurred in this pass (including this cycle's compare) or `limit == 1`: write `pass_count`, pulse `sorting_done`, go to DRAIN;
  - otherwise: `j <= 0`, `swapped <= 0`.
- `in_valid` is ignored.

**DRAIN**
- `out_valid`=1 and `out_data = arr[rd_idx]`.
- `out_data` is held stable while `out_valid && !out_ready`.
- Each handshake increments `rd_idx`.
- On the handshake at `rd_idx == DEPTH-1`: clear `rd_idx` and `wr_idx`, set `in_ready <= 1`, go to LOAD.
- `in_valid` is ignored.

**Reset** (asynchronous, takes effect immediately, including mid-SORT or mid-DRAIN)
- State returns to LOAD.
- The array and all counters are cleared.
- All outputs are 0, including `in_ready`.
- `in_ready` rises at the first rising edge after `rst` deasserts. No handshake is accepted while `rst` is high.

## Timing

- **Reset values:** `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `sorting_done`=0, `pass_count`=0.
- **Load:** one element per cycle at full rate. DEPTH cycles minimum.
- **Start of sort:** the first compare happens in the cycle after the last input handshake. `busy` rises on that same edge.
- **SORT length:** one cycle per compare.
  - Best case (already sorted): DEPTH-1 cycles, `pass_count`=1.
  - Worst case: DEPTH·(DEPTH-1)/2 cycles, which is 105 for DEPTH=15, with `pass_count`=DEPTH-1.
- **End of sort:** `sorting_done`, `out_valid` rise and `busy` falls on the same edge, immediately after the final compare. `sorting_done` lasts exactly one cycle.
- **Drain:** DEPTH cycles at full rate. The throughput counter extends one cycle per cycle of `out_ready`=0.
- **Return to LOAD:** `in_ready` rises in the cycle after the last output handshake. There is no overlap between drain and the next load.

## Test plan

1. **Reset:** hold `rst` high for 25 ns with `in_valid`=1.
   - While in reset: all outputs are 0 and nothing is loaded.
   - `in_ready`=1 after the first edge post-release.
2. **Reverse input, ascending:** load 15,14,…,1 with `descend`=0.
   - `sorting_done` pulses 105 cycles after the first compare.
   - Drain returns 1..15 and `pass_count`=14.
3. **Sorted input, early termination:** load 1..15 with `descend`=0.
   - `sorting_done` pulses after 14 SORT cycles.
   - `pass_count`=1 and the output equals the input.
4. **Descending with duplicates and extremes:** load 5,3,5,0,255,7,7,1,255,2,9,0,4,8,6 with `descend`=1.
   - Output is 255,255,9,8,7,7,6,5,5,4,3,2,1,0,0.
   - `descend` toggling during SORT has no effect.
5. **Output backpressure:** randomly toggle `out_ready`.
   - `out_data` is stable while stalled; all 15 elements are delivered in order with none duplicated.
   - `in_ready`=1 the cycle after the 15th handshake.
   - A second sort back-to-back is correct.
6. **Reset mid-operation:** assert `rst` 40 cycles into SORT.
   - All outputs go to 0 immediately.
   - A fresh load of 15 random values then sorts correctly against a reference model.
